id_ex_pipe: RTL and testbench

Parametrised ID→EX pipeline stage with a valid/ready handshake and a one-entry skid buffer. ID can push one decoded instruction per cycle while EX applies backpressure, with no loss and no combinational ready path. It supports a synchronous flush for branch or exception kill and inserts NOP bubbles toward EX whenever it is empty. A saturating stall counter is provided for performance debug.

---
 rtl/id_ex_if.sv | 42 ++++
 rtl/id_ex_pipe.sv | 108 ++++++++++
 tb/tb_id_ex_pipe.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/id_ex_if.sv
// rtl/id_ex_if.sv - ID to EX handshake and payload bundle
interface id_ex_if #(
  parameter int DATA_W   = 32,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter int RADDR_W  = 5
);
  logic                id_valid;
  logic                id_ready;
  logic [ALUOP_W-1:0]  id_aluop;
  logic [ALUSEL_W-1:0] id_alusel;
  logic [DATA_W-1:0]   id_rdata1;
  logic [DATA_W-1:0]   id_rdata2;
  logic [RADDR_W-1:0]  id_rw;
  logic                id_wreg;
  logic                id_delayslot;

  logic                ex_valid;
  logic                ex_ready;
  logic [ALUOP_W-1:0]  ex_aluop;
  logic [ALUSEL_W-1:0] ex_alusel;
  logic [DATA_W-1:0]   ex_rdata1;
  logic [DATA_W-1:0]   ex_rdata2;
  logic [RADDR_W-1:0]  ex_rw;
  logic                ex_wreg;
  logic                ex_delayslot;

  // The environment (ID producer plus EX consumer) drives the stage.
  modport master (
    output id_valid, id_aluop, id_alusel, id_rdata1, id_rdata2, id_rw, id_wreg, id_delayslot,
    output ex_ready,
    input  id_ready,
    input  ex_valid, ex_aluop, ex_alusel, ex_rdata1, ex_rdata2, ex_rw, ex_wreg, ex_delayslot
  );

  modport slave (
    input  id_valid, id_aluop, id_alusel, id_rdata1, id_rdata2, id_rw, id_wreg, id_delayslot,
    input  ex_ready,
    output id_ready,
    output ex_valid, ex_aluop, ex_alusel, ex_rdata1, ex_rdata2, ex_rw, ex_wreg, ex_delayslot
  );
endinterface

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with skid buffer, flush and stall counter
module id_ex_pipe #(
  parameter int                  DATA_W     = 32,
  parameter int                  ALUOP_W    = 8,
  parameter int                  ALUSEL_W   = 3,
  parameter int                  RADDR_W    = 5,
  parameter int                  CNT_W      = 16,
  parameter logic [ALUOP_W-1:0]  NOP_ALUOP  = '0,
  parameter logic [ALUSEL_W-1:0] NOP_ALUSEL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  id_ex_if.slave           io,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int PW = ALUOP_W + ALUSEL_W + 2 * DATA_W + RADDR_W + 2;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t              state;
  logic                id_ready_q;
  logic                ex_valid_q;
  logic [PW-1:0]       main_q;
  logic [PW-1:0]       skid_q;
  logic [PW-1:0]       id_pl;
  logic                push;
  logic                pop;

  logic [ALUOP_W-1:0]  m_aluop;
  logic [ALUSEL_W-1:0] m_alusel;
  logic [DATA_W-1:0]   m_rdata1;
  logic [DATA_W-1:0]   m_rdata2;
  logic [RADDR_W-1:0]  m_rw;
  logic                m_wreg;
  logic                m_delayslot;

  assign id_pl = {io.id_aluop, io.id_alusel, io.id_rdata1, io.id_rdata2,
                  io.id_rw, io.id_wreg, io.id_delayslot};
  assign push  = io.id_valid & id_ready_q;
  assign pop   = ex_valid_q & io.ex_ready;

  // Handshake flags are registered alongside the state so id_ready never sees ex_ready.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= EMPTY;
      id_ready_q <= 1'b1;
      ex_valid_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
      stall_cnt  <= '0;
    end else begin
      if (ex_valid_q && !io.ex_ready && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_ONE;

      if (flush) begin
        state      <= EMPTY;
        id_ready_q <= 1'b1;
        ex_valid_q <= 1'b0;
      end else begin
        case (state)
          EMPTY: if (push) begin
            main_q     <= id_pl;
            state      <= BUSY;
            ex_valid_q <= 1'b1;
          end
          BUSY: begin
            if (push && pop) begin
              main_q <= id_pl;
            end else if (push) begin
              skid_q     <= id_pl;
              state      <= FULL;
              id_ready_q <= 1'b0;
            end else if (pop) begin
              state      <= EMPTY;
              ex_valid_q <= 1'b0;
            end
          end
          FULL: if (pop) begin
            main_q     <= skid_q;
            state      <= BUSY;
            id_ready_q <= 1'b1;
          end
          default: begin
            state      <= EMPTY;
            id_ready_q <= 1'b1;
            ex_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign {m_aluop, m_alusel, m_rdata1, m_rdata2, m_rw, m_wreg, m_delayslot} = main_q;

  // Bubbles: stale main entry is masked so EX never sees a write enable without valid.
  assign io.id_ready     = id_ready_q;
  assign io.ex_valid     = ex_valid_q;
  assign io.ex_aluop     = ex_valid_q ? m_aluop     : NOP_ALUOP;
  assign io.ex_alusel    = ex_valid_q ? m_alusel    : NOP_ALUSEL;
  assign io.ex_rdata1    = ex_valid_q ? m_rdata1    : '0;
  assign io.ex_rdata2    = ex_valid_q ? m_rdata2    : '0;
  assign io.ex_rw        = ex_valid_q ? m_rw        : '0;
  assign io.ex_wreg      = ex_valid_q & m_wreg;
  assign io.ex_delayslot = ex_valid_q & m_delayslot;
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - table and scoreboard bench for id_ex_pipe
module tb_id_ex_pipe;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  id_ex_if #(.DATA_W(32), .ALUOP_W(8), .ALUSEL_W(3), .RADDR_W(5)) bus ();

  id_ex_pipe #(.DATA_W(32), .ALUOP_W(8), .ALUSEL_W(3), .RADDR_W(5), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .io        (bus.slave),
    .stall_cnt (stall_cnt)
  );

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [4:0]  rw;
    logic        wreg;
    logic        ds;
  } pl_t;

  typedef struct {
    bit         iv, er, fl, rs;
    logic [7:0] a;
    bit         x_idr, x_exv;
    logic [7:0] x_al;
    bit         cs;
  } row_t;

  pl_t  q[$];
  row_t tbl[$];
  int   errors = 0;
  int   checks = 0;
  bit   started = 0;

  function automatic pl_t mk(input logic [7:0] a);
    pl_t p;
    p.aluop  = a;
    p.alusel = a[2:0];
    p.rdata1 = {4{a}};
    p.rdata2 = ~{4{a}};
    p.rw     = a[4:0];
    p.wreg   = a[0];
    p.ds     = a[1];
    return p;
  endfunction

  function automatic pl_t ex_pl();
    return {bus.ex_aluop, bus.ex_alusel, bus.ex_rdata1, bus.ex_rdata2,
            bus.ex_rw, bus.ex_wreg, bus.ex_delayslot};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input bit iv, er, fl, rs, input logic [7:0] a,
                     input bit x_idr, x_exv, input logic [7:0] x_al, input bit cs);
    row_t r;
    r.iv = iv; r.er = er; r.fl = fl; r.rs = rs; r.a = a;
    r.x_idr = x_idr; r.x_exv = x_exv; r.x_al = x_al; r.cs = cs;
    tbl.push_back(r);
  endtask

  // Drive one cycle: check occupancy model and scoreboard before the edge, then advance.
  task automatic cycle(input bit iv, er, fl, rs, input pl_t p);
    rst = rs;
    flush = fl;
    bus.ex_ready = er;
    bus.id_valid = iv;
    {bus.id_aluop, bus.id_alusel, bus.id_rdata1, bus.id_rdata2,
     bus.id_rw, bus.id_wreg, bus.id_delayslot} = p;
    if (started) begin
      chk("model_id_ready", 128'(bus.id_ready), 128'(q.size() < 2));
      chk("model_ex_valid", 128'(bus.ex_valid), 128'(q.size() > 0));
      if (!bus.ex_valid) chk("bubble_payload", 128'(ex_pl()), 128'(0));
    end
    if (!rs) q.delete();
    else begin
      if (bus.ex_valid && er) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: got pop with %0d queued expected at least 1", q.size());
        end else begin
          checks--;
          chk("sb_order", 128'(ex_pl()), 128'(q[0]));
          void'(q.pop_front());
        end
      end
      if (fl) q.delete();
      else if (iv && bus.id_ready) q.push_back(p);
    end
    @(posedge clk);
    #1;
    if (!rs) started = 1;
  endtask

  initial begin
    pl_t wide;
    bus.id_valid = 0; bus.ex_ready = 0;
    {bus.id_aluop, bus.id_alusel, bus.id_rdata1, bus.id_rdata2,
     bus.id_rw, bus.id_wreg, bus.id_delayslot} = '0;

    // iv er fl rs a | id_ready ex_valid ex_aluop | check stall==0
    add(0,0,0,0, 0,  1,0, 0, 1);
    add(1,1,0,1, 1,  1,1, 1, 0);
    add(1,1,0,1, 2,  1,1, 2, 0);
    add(1,1,0,1, 3,  1,1, 3, 0);
    add(1,1,0,1, 4,  1,1, 4, 0);
    add(0,1,0,1, 0,  1,0, 0, 0);
    add(1,0,0,1, 10, 1,1, 10, 0);
    add(1,0,0,1, 11, 0,1, 10, 0);
    add(0,1,0,1, 0,  1,1, 11, 0);
    add(0,1,0,1, 0,  1,0, 0, 0);
    add(1,0,0,1, 20, 1,1, 20, 0);
    add(1,0,0,1, 21, 0,1, 20, 0);
    add(1,0,1,1, 22, 1,0, 0, 0);
    add(0,0,0,1, 0,  1,0, 0, 0);
    add(1,0,0,1, 23, 1,1, 23, 0);
    add(1,1,1,1, 24, 1,0, 0, 0);
    add(0,1,0,1, 0,  1,0, 0, 0);
    add(1,0,0,1, 30, 1,1, 30, 0);
    add(1,0,0,1, 31, 0,1, 30, 0);
    add(1,0,1,0, 32, 1,0, 0, 1);
    add(1,0,0,1, 33, 1,1, 33, 0);
    add(0,1,0,1, 0,  1,0, 0, 0);

    foreach (tbl[i]) begin
      cycle(tbl[i].iv, tbl[i].er, tbl[i].fl, tbl[i].rs, mk(tbl[i].a));
      chk($sformatf("row%0d_id_ready", i), 128'(bus.id_ready), 128'(tbl[i].x_idr));
      chk($sformatf("row%0d_ex_valid", i), 128'(bus.ex_valid), 128'(tbl[i].x_exv));
      chk($sformatf("row%0d_ex_aluop", i), 128'(bus.ex_aluop), 128'(tbl[i].x_al));
      if (tbl[i].cs) chk($sformatf("row%0d_stall_cnt", i), 128'(stall_cnt), 128'(0));
    end

    // Saturating stall counter with a held entry.
    cycle(0,0,0,0, mk(0));
    cycle(1,0,0,1, mk(40));
    chk("stall_start", 128'(stall_cnt), 128'(0));
    for (int k = 1; k <= 20; k++) begin
      cycle(0,0,0,1, mk(0));
      chk($sformatf("stall_k%0d", k), 128'(stall_cnt), 128'((k > 15) ? 15 : k));
    end
    cycle(0,1,0,1, mk(0));
    for (int k = 0; k < 3; k++) cycle(0,0,0,1, mk(0));
    chk("stall_hold_idle", 128'(stall_cnt), 128'(15));

    // Full-width payload boundary values.
    wide.aluop = 8'hFF; wide.alusel = 3'h7; wide.rdata1 = 32'hFFFF_FFFF;
    wide.rdata2 = 32'h8000_0001; wide.rw = 5'd31; wide.wreg = 1'b1; wide.ds = 1'b1;
    cycle(1,1,0,1, wide);
    chk("wide_payload", 128'(ex_pl()), 128'(wide));
    chk("wide_valid", 128'(bus.ex_valid), 128'(1));
    cycle(0,1,0,1, mk(0));
    chk("after_pop_valid", 128'(bus.ex_valid), 128'(0));
    chk("after_pop_wreg", 128'(bus.ex_wreg), 128'(0));
    chk("after_pop_rw", 128'(bus.ex_rw), 128'(0));
    cycle(0,1,0,1, mk(0));
    chk("sb_drained", 128'(q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
